// File: rtl/point_scheduler.sv
// rtl/point_scheduler.sv - round-robin time-multiplexer of point sources onto one LEDdisplay driver
// Each requesting source is shown for HOLD cycles, and one blank SCAN cycle separates each pair of sources.
module point_scheduler #(
  parameter int NPTS = 4,
  parameter int HOLD = 12500,
  parameter int CW   = 14
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pause,
  input  logic [NPTS-1:0]   req,
  input  logic [3*NPTS-1:0] pt_x,
  input  logic [3*NPTS-1:0] pt_y,
  input  logic [3*NPTS-1:0] pt_z,
  input  logic [3*NPTS-1:0] pt_c,
  output logic [NPTS-1:0]   grant,
  output logic [3:0]        oX,
  output logic [3:0]        oY,
  output logic [3:0]        oZ,
  output logic [3:0]        color,
  output logic              led_en,
  output logic              frame_done
);

  localparam int PW = (NPTS > 1) ? $clog2(NPTS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, SHOW} state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   gidx_q;
  logic [CW-1:0]   cnt_q;
  logic [NPTS-1:0] grant_q;
  logic [3:0]      ox_q, oy_q, oz_q, oc_q;
  logic            led_en_q;
  logic            frame_done_q;

  logic [2*NPTS-1:0] rot;
  logic              found;
  logic [PW-1:0]     off;
  logic [PW:0]       sum;
  logic [PW-1:0]     scan_idx;
  logic [2:0]        sel_x, sel_y, sel_z, sel_c;
  logic [NPTS-1:0]   above_mask;
  logic              release_now;
  logic              dwell_done;
  logic [PW-1:0]     ptr_d;

  // Rotate the request vector so the search always starts at bit 0, then map back to an index.
  always_comb begin
    rot   = {req, req} >> ptr_q;
    found = 1'b0;
    off   = '0;
    for (int k = 0; k < NPTS; k++) begin
      if (!found && rot[0]) begin
        found = 1'b1;
        off   = PW'(k);
      end
      rot = rot >> 1;
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= (PW+1)'(NPTS)) begin
      sum = sum - (PW+1)'(NPTS);
    end
    scan_idx = sum[PW-1:0];
    sel_x    = 3'(pt_x >> (3 * scan_idx));
    sel_y    = 3'(pt_y >> (3 * scan_idx));
    sel_z    = 3'(pt_z >> (3 * scan_idx));
    sel_c    = 3'(pt_c >> (3 * scan_idx));
  end

  always_comb begin
    above_mask  = ~((grant_q << 1) - NPTS'(1));
    release_now = ~|(req & grant_q);
    dwell_done  = !pause && (cnt_q == CW'(HOLD - 1));
    ptr_d       = grant_q[NPTS-1] ? '0 : gidx_q + PW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      gidx_q       <= '0;
      cnt_q        <= '0;
      grant_q      <= '0;
      ox_q         <= '0;
      oy_q         <= '0;
      oz_q         <= '0;
      oc_q         <= '0;
      led_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) state_q <= SCAN;
        end
        SCAN: begin
          if (found) begin
            state_q  <= SHOW;
            gidx_q   <= scan_idx;
            grant_q  <= NPTS'(1) << scan_idx;
            led_en_q <= 1'b1;
            ox_q     <= {1'b0, sel_x};
            oy_q     <= {1'b0, sel_y};
            oz_q     <= {1'b0, sel_z};
            oc_q     <= {1'b0, sel_c};
            cnt_q    <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        SHOW: begin
          // Early release wins over pause; the blank cycle follows every exit.
          if (release_now || dwell_done) begin
            state_q      <= SCAN;
            ptr_q        <= ptr_d;
            grant_q      <= '0;
            led_en_q     <= 1'b0;
            ox_q         <= '0;
            oy_q         <= '0;
            oz_q         <= '0;
            oc_q         <= '0;
            frame_done_q <= ~|(req & above_mask);
          end else if (!pause) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant      = grant_q;
  assign oX         = ox_q;
  assign oY         = oy_q;
  assign oZ         = oz_q;
  assign color      = oc_q;
  assign led_en     = led_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_point_scheduler.sv
// tb/tb_point_scheduler.sv - randomized bench for point_scheduler against a behavioural model
module tb_point_scheduler;

  localparam int NPTS = 4;
  localparam int HOLD = 4;
  localparam int CW   = 3;
  localparam int FW   = 3 * NPTS;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            pause = 1'b0;
  logic [NPTS-1:0] req = '0;
  logic [FW-1:0]   pt_x = '0, pt_y = '0, pt_z = '0, pt_c = '0;
  logic [NPTS-1:0] grant;
  logic [3:0]      oX, oY, oZ, color;
  logic            led_en, frame_done;

  point_scheduler #(.NPTS(NPTS), .HOLD(HOLD), .CW(CW)) dut (
    .clk(clk), .resetn(resetn), .pause(pause), .req(req),
    .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z), .pt_c(pt_c),
    .grant(grant), .oX(oX), .oY(oY), .oZ(oZ), .color(color),
    .led_en(led_en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: which source is lit (-1 none), how many active dwell cycles it has had,
  // whether a selection happens at the next edge, and where the search starts.
  int         m_src;
  int         m_dwell;
  int         m_ptr;
  bit         m_scan;
  bit         m_fd;
  logic [3:0] m_x, m_y, m_z, m_c;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_src = -1; m_dwell = 0; m_ptr = 0; m_scan = 0; m_fd = 0;
    m_x = 0; m_y = 0; m_z = 0; m_c = 0;
  endtask

  task automatic model_step();
    int  s;
    bit  higher;
    m_fd = 0;
    if (m_src >= 0) begin
      if (!req[m_src] || (!pause && m_dwell == HOLD - 1)) begin
        higher = 0;
        for (int j = m_src + 1; j < NPTS; j++) if (req[j]) higher = 1;
        m_fd   = !higher;
        m_ptr  = (m_src + 1) % NPTS;
        m_src  = -1;
        m_scan = 1;
        m_x = 0; m_y = 0; m_z = 0; m_c = 0;
      end else if (!pause) begin
        m_dwell++;
      end
    end else if (m_scan) begin
      s = -1;
      for (int k = 0; k < NPTS; k++) begin
        int idx;
        idx = (m_ptr + k) % NPTS;
        if (s < 0 && req[idx]) s = idx;
      end
      m_scan = 0;
      if (s >= 0) begin
        m_src   = s;
        m_dwell = 0;
        m_x = {1'b0, pt_x[3*s +: 3]};
        m_y = {1'b0, pt_y[3*s +: 3]};
        m_z = {1'b0, pt_z[3*s +: 3]};
        m_c = {1'b0, pt_c[3*s +: 3]};
      end
    end else if (req != 0) begin
      m_scan = 1;
    end
  endtask

  task automatic compare_all();
    check("grant", 32'(grant), (m_src >= 0) ? (32'd1 << m_src) : 32'd0);
    check("led_en", 32'(led_en), 32'(m_src >= 0));
    check("fields", 32'({oX, oY, oZ, color}), 32'({m_x, m_y, m_z, m_c}));
    check("frame_done", 32'(frame_done), 32'(m_fd));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  int         seq[$];
  logic [3:0] last_g;
  bit         got_show;
  int         first_g;

  initial begin
    model_reset();
    @(negedge clk);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_outs", 32'({oX, oY, oZ, color, led_en, frame_done}), 32'd0);
    resetn = 1'b1;

    repeat (100) cycle();

    pt_x = {3'd4, 3'd3, 3'd2, 3'd1};
    pt_y = {3'd5, 3'd6, 3'd7, 3'd0};
    pt_z = {3'd1, 3'd3, 3'd5, 3'd7};
    pt_c = {3'd0, 3'd2, 3'd4, 3'd6};
    req  = 4'b1011;
    last_g = '0;
    repeat (24) begin
      cycle();
      if (grant != 0 && last_g == 0) seq.push_back(int'(grant));
      last_g = grant;
    end
    check("seq_len_ge4", 32'(seq.size() >= 4), 32'd1);
    if (seq.size() >= 4) begin
      check("seq0", 32'(seq[0]), 32'b0001);
      check("seq1", 32'(seq[1]), 32'b0010);
      check("seq2", 32'(seq[2]), 32'b1000);
      check("seq3", 32'(seq[3]), 32'b0001);
    end

    repeat (2500) begin
      if ($urandom_range(0, 3) == 0) req = req ^ NPTS'(1 << $urandom_range(0, NPTS - 1));
      if ($urandom_range(0, 60) == 0) req = '0;
      pause = ($urandom_range(0, 4) == 0);
      pt_x  = FW'($urandom);
      pt_y  = FW'($urandom);
      pt_z  = FW'($urandom);
      pt_c  = FW'($urandom);
      cycle();
    end

    pause = 1'b0;
    req   = 4'b1100;
    got_show = 0;
    for (int i = 0; i < 20 && !got_show; i++) begin
      cycle();
      if (led_en) got_show = 1;
    end
    check("wait_show", 32'(got_show), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("async_grant", 32'(grant), 32'd0);
    check("async_led_en", 32'(led_en), 32'd0);
    check("async_fields", 32'({oX, oY, oZ, color}), 32'd0);
    check("async_fd", 32'(frame_done), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    req    = 4'b1111;
    model_reset();
    compare_all();
    first_g = 0;
    repeat (4) begin
      cycle();
      if (first_g == 0 && grant != 0) first_g = int'(grant);
    end
    check("first_grant_after_reset", 32'(first_g), 32'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
